// File: rtl/phase_rst_ctrl.sv
// Push-button reset sequencer: debounces btn_n, generates rotating phase enables and
// releases core_rst only after a hold period, aligned to the start of phase 0.
module phase_rst_ctrl #(
  parameter int NPHASE      = 3,
  parameter int DEB_LEN     = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int PHASE_MODE  = 1
) (
  input  logic              clk_core,
  input  logic              rst_n,
  input  logic              btn_n,
  output logic [NPHASE-1:0] phase_en,
  output logic              core_rst,
  output logic              btn_stable,
  output logic [7:0]        press_cnt
);

  localparam int            CW         = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam logic [CW-1:0] LAST_PHASE = CW'(NPHASE - 1);
  localparam logic          ALIGN_FREE = (PHASE_MODE == 0) || (NPHASE == 1);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    HOLD   = 2'd1,
    ALIGN  = 2'd2,
    RUN    = 2'd3
  } state_t;

  logic               sync1_q;
  logic               sync2_q;
  logic [DEB_LEN-1:0] shift_q, shift_d;
  logic               stable_q, stable_d;
  logic [7:0]         press_q, press_d;
  logic [CW-1:0]      phase_q, phase_d;
  logic [NPHASE-1:0]  phase_en_q, phase_en_d;
  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               core_rst_q, core_rst_d;

  // State register; rst_n is synchronous and overrides everything.
  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      shift_q    <= {DEB_LEN{1'b0}};
      stable_q   <= 1'b0;
      press_q    <= 8'd0;
      phase_q    <= {CW{1'b0}};
      phase_en_q <= {NPHASE{1'b0}};
      state_q    <= ASSERT;
      hold_q     <= 8'd0;
      core_rst_q <= 1'b1;
    end else begin
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      shift_q    <= shift_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      phase_q    <= phase_d;
      phase_en_q <= phase_en_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
    end
  end

  // Debounce filter, press counter and phase rotation.
  always_comb begin
    shift_d = {shift_q[DEB_LEN-2:0], sync2_q};
    if (&shift_q) begin
      stable_d = 1'b1;
    end else if (~|shift_q) begin
      stable_d = 1'b0;
    end else begin
      stable_d = stable_q;
    end

    if (stable_q && !stable_d && (press_q != 8'd255)) begin
      press_d = press_q + 8'd1;
    end else begin
      press_d = press_q;
    end

    if (phase_q == LAST_PHASE) begin
      phase_d = {CW{1'b0}};
    end else begin
      phase_d = phase_q + CW'(1);
    end

    phase_en_d = {NPHASE{1'b1}};
    if (PHASE_MODE != 0) begin
      for (int i = 0; i < NPHASE; i++) begin
        phase_en_d[i] = (phase_q == CW'(i));
      end
    end else begin
      phase_en_d = {NPHASE{1'b1}};
    end
  end

  // Reset sequencer. ALIGN watches the enable currently active, so leaving on the last
  // phase makes core_rst fall on the very edge phase_en[0] rises.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ASSERT: begin
        if (stable_q) begin
          state_d = HOLD;
          hold_d  = 8'(HOLD_CYCLES);
        end else begin
          state_d = ASSERT;
        end
      end
      HOLD: begin
        if (!stable_q) begin
          state_d = ASSERT;
          hold_d  = 8'd0;
        end else if (hold_q <= 8'd1) begin
          state_d = ALIGN;
          hold_d  = 8'd0;
        end else begin
          hold_d  = hold_q - 8'd1;
        end
      end
      ALIGN: begin
        if (!stable_q) begin
          state_d = ASSERT;
        end else if (ALIGN_FREE || phase_en_q[NPHASE-1]) begin
          state_d = RUN;
        end else begin
          state_d = ALIGN;
        end
      end
      RUN: begin
        if (!stable_q) begin
          state_d = ASSERT;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = ASSERT;
        hold_d  = 8'd0;
      end
    endcase
    core_rst_d = (state_d != RUN);
  end

  assign phase_en   = phase_en_q;
  assign core_rst   = core_rst_q;
  assign btn_stable = stable_q;
  assign press_cnt  = press_q;

endmodule

// File: tb/tb_phase_rst_ctrl.sv
// Bench for phase_rst_ctrl: one-hot instance and bypass instance driven in parallel,
// checked every cycle against a window/arithmetic model plus hand-computed checkpoints.
module tb_phase_rst_ctrl;

  localparam int NP = 3;
  localparam int DL = 4;
  localparam int HC = 2;

  logic          clk_core = 1'b0;
  logic          rst_n;
  logic          btn_n;
  logic [NP-1:0] pe1, pe0;
  logic          core1, core0, stab1, stab0;
  logic [7:0]    press1, press0;

  int test_id  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_core = ~clk_core;

  phase_rst_ctrl #(.NPHASE(NP), .DEB_LEN(DL), .HOLD_CYCLES(HC), .PHASE_MODE(1)) u_dut (
    .clk_core(clk_core), .rst_n(rst_n), .btn_n(btn_n),
    .phase_en(pe1), .core_rst(core1), .btn_stable(stab1), .press_cnt(press1)
  );

  phase_rst_ctrl #(.NPHASE(NP), .DEB_LEN(DL), .HOLD_CYCLES(HC), .PHASE_MODE(0)) u_byp (
    .clk_core(clk_core), .rst_n(rst_n), .btn_n(btn_n),
    .phase_en(pe0), .core_rst(core0), .btn_stable(stab0), .press_cnt(press0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (test %0d): got %0h, expected %0h", name, test_id, act, exp);
    end
  endtask

  // Model: btn_stable after edge k follows the btn_n samples taken at edges k-DL-2..k-3
  // (samples at or before the last reset count as 0); core_rst release edge is computed
  // arithmetically from the edge where btn_stable rose.
  int            k = 0;
  int            last_rst = 0;
  int            tcyc = 0;
  int            prev_id = 0;
  logic          samp[$];
  logic          m_stable = 1'b0;
  int            m_press = 0;
  int            run1 = 0;
  int            run0 = 0;
  logic          m_core1 = 1'b1;
  logic          m_core0 = 1'b1;
  logic [NP-1:0] m_pe1 = '0;
  logic [NP-1:0] m_pe0 = '0;
  logic          prev_core1 = 1'b1;

  task automatic model_step();
    logic all1, all0, nxt;
    k++;
    if (!rst_n) begin
      last_rst = k;
      samp = {};
      for (int i = 0; i < DL + 3; i++) samp.push_back(1'b0);
      m_stable = 1'b0;
      m_press  = 0;
      m_core1  = 1'b1;
      m_core0  = 1'b1;
      m_pe1    = '0;
      m_pe0    = '0;
    end else begin
      samp.push_back(btn_n);
      void'(samp.pop_front());
      all1 = 1'b1;
      all0 = 1'b1;
      for (int i = 0; i < DL; i++) begin
        if (samp[i]) all0 = 1'b0;
        else         all1 = 1'b0;
      end
      nxt = all1 ? 1'b1 : (all0 ? 1'b0 : m_stable);
      m_core1 = !m_stable || (k < run1);
      m_core0 = !m_stable || (k < run0);
      if (m_stable && !nxt && m_press < 255) m_press++;
      if (!m_stable && nxt) begin
        run0 = k + HC + 2;
        run1 = run0;
        while (((run1 - last_rst - 1) % NP) != 0) run1++;
      end
      m_stable = nxt;
      m_pe1 = NP'(1) << ((k - last_rst - 1) % NP);
      m_pe0 = {NP{1'b1}};
    end
  endtask

  // Compare process: #1 after each rising edge, inputs are still those sampled by the edge.
  initial begin
    forever begin
      @(posedge clk_core);
      #1;
      if (test_id != prev_id) begin
        prev_id = test_id;
        tcyc = 1;
      end else begin
        tcyc++;
      end
      model_step();

      check("phase_en",       {29'd0, pe1},    {29'd0, m_pe1});
      check("core_rst",       {31'd0, core1},  {31'd0, m_core1});
      check("btn_stable",     {31'd0, stab1},  {31'd0, m_stable});
      check("press_cnt",      {24'd0, press1}, m_press);
      check("byp_phase_en",   {29'd0, pe0},    {29'd0, m_pe0});
      check("byp_core_rst",   {31'd0, core0},  {31'd0, m_core0});
      check("byp_btn_stable", {31'd0, stab0},  {31'd0, m_stable});
      check("byp_press_cnt",  {24'd0, press0}, m_press);
      if (prev_core1 === 1'b1 && core1 === 1'b0) check("release_aligned", {29'd0, pe1}, 32'd1);
      prev_core1 = core1;

      if (test_id == 1) begin
        if (tcyc == 5)  begin
          check("lit_rst_pe", {29'd0, pe1}, 32'd0);
          check("lit_rst_core", {31'd0, core1}, 32'd1);
        end
        if (tcyc == 6)  begin
          check("lit_c1_pe", {29'd0, pe1}, 32'd1);
          check("lit_c1_byp_pe", {29'd0, pe0}, 32'd7);
        end
        if (tcyc == 7)  check("lit_c2_pe", {29'd0, pe1}, 32'd2);
        if (tcyc == 8)  check("lit_c3_pe", {29'd0, pe1}, 32'd4);
        if (tcyc == 11) check("lit_c6_stable", {31'd0, stab1}, 32'd0);
        if (tcyc == 12) check("lit_c7_stable", {31'd0, stab1}, 32'd1);
        if (tcyc == 15) check("lit_c10_byp_core", {31'd0, core0}, 32'd1);
        if (tcyc == 16) check("lit_c11_byp_core", {31'd0, core0}, 32'd0);
        if (tcyc == 17) check("lit_c12_core", {31'd0, core1}, 32'd1);
        if (tcyc == 18) begin
          check("lit_c13_core", {31'd0, core1}, 32'd0);
          check("lit_c13_pe", {29'd0, pe1}, 32'd1);
        end
      end
      if (test_id == 2) begin
        if (tcyc == 8)  check("lit_glitch_stable", {31'd0, stab1}, 32'd1);
        if (tcyc == 18) begin
          check("lit_glitch_core", {31'd0, core1}, 32'd0);
          check("lit_glitch_press", {24'd0, press1}, 32'd0);
        end
      end
      if (test_id == 3) begin
        if (tcyc == 6) check("lit_press_stable_hi", {31'd0, stab1}, 32'd1);
        if (tcyc == 7) begin
          check("lit_press_stable_lo", {31'd0, stab1}, 32'd0);
          check("lit_press_cnt1", {24'd0, press1}, 32'd1);
          check("lit_press_core_lo", {31'd0, core1}, 32'd0);
        end
        if (tcyc == 8)  check("lit_press_core_hi", {31'd0, core1}, 32'd1);
        if (tcyc == 20) check("lit_press_byp_core_hi", {31'd0, core0}, 32'd1);
        if (tcyc == 21) check("lit_press_byp_core_lo", {31'd0, core0}, 32'd0);
        if (tcyc == 35) check("lit_press_rerun", {31'd0, core1}, 32'd0);
      end
      if (test_id == 4) begin
        if (tcyc == 7)  check("lit_t4_press2", {24'd0, press1}, 32'd2);
        if (tcyc == 16) begin
          check("lit_hold_core", {31'd0, core1}, 32'd1);
          check("lit_hold_stable", {31'd0, stab1}, 32'd1);
        end
        if (tcyc == 17) begin
          check("lit_hold_rst_pe", {29'd0, pe1}, 32'd0);
          check("lit_hold_rst_byp_pe", {29'd0, pe0}, 32'd0);
          check("lit_hold_rst_stable", {31'd0, stab1}, 32'd0);
          check("lit_hold_rst_press", {24'd0, press1}, 32'd0);
          check("lit_hold_rst_core", {31'd0, core1}, 32'd1);
        end
        if (tcyc == 39) check("lit_after_rst_run", {31'd0, core1}, 32'd0);
      end
      if (test_id == 5 && tcyc == 3610) check("lit_press_sat", {24'd0, press1}, 32'd255);
    end
  end

  // Directed stimulus; inputs change only on falling edges.
  initial begin
    rst_n   = 1'b0;
    btn_n   = 1'b1;
    test_id = 1;
    repeat (5) @(negedge clk_core);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_core);

    test_id = 2;
    btn_n   = 1'b0;
    repeat (3) @(negedge clk_core);
    btn_n = 1'b1;
    repeat (15) @(negedge clk_core);

    test_id = 3;
    btn_n   = 1'b0;
    repeat (10) @(negedge clk_core);
    btn_n = 1'b1;
    repeat (25) @(negedge clk_core);

    test_id = 4;
    btn_n   = 1'b0;
    repeat (8) @(negedge clk_core);
    btn_n = 1'b1;
    repeat (8) @(negedge clk_core);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_core);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_core);

    test_id = 5;
    for (int p = 0; p < 300; p++) begin
      btn_n = 1'b0;
      repeat (6) @(negedge clk_core);
      btn_n = 1'b1;
      repeat (6) @(negedge clk_core);
    end
    repeat (10) @(negedge clk_core);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
